// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: drives the PLL reset, qualifies the asynchronous lock
// indication and releases per-domain resets in a staggered order.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES         = 2,
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int NUM_DOMAINS         = 4,
  parameter int STAGGER_CYCLES      = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   locked_in,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   ready,
  output logic [7:0]             retry_count,
  output logic [7:0]             loss_count
);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  localparam logic [31:0] RST_LAST     = 32'(RST_PULSE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [31:0] STABLE_LAST  = 32'(LOCK_STABLE_CYCLES - 1);
  localparam logic [31:0] RELEASE_LAST = 32'((NUM_DOMAINS - 1) * STAGGER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   lock_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic [31:0]            cnt_r;

  logic                   pll_rst_r;
  logic [NUM_DOMAINS-1:0] domain_rst_n_r;
  logic                   ready_r;
  logic [7:0]             retry_count_r;
  logic [7:0]             loss_count_r;

  logic                   pll_rst_nxt_s;
  logic [NUM_DOMAINS-1:0] domain_rst_n_nxt_s;
  logic                   ready_nxt_s;
  logic [7:0]             retry_count_nxt_s;
  logic [7:0]             loss_count_nxt_s;

  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    if (value == 8'hFF) begin
      return value;
    end else begin
      return value + 8'd1;
    end
  endfunction

  // Lock synchronizer: only the last stage is used by the rest of the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign lock_s = sync_r[SYNC_STAGES-1];

  // State register and the shared cycle counter, cleared on every transition.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= PLL_RESET;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      if (state_nxt_s != state_r) begin
        cnt_r <= 32'd0;
      end else if (state_r != RUN) begin
        cnt_r <= cnt_r + 32'd1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Next-state logic; lock loss in RELEASE/RUN outranks any scheduled release.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      PLL_RESET: begin
        if (cnt_r == RST_LAST) begin
          state_nxt_s = WAIT_LOCK;
        end else begin
          state_nxt_s = PLL_RESET;
        end
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_nxt_s = STABLE;
        end else if (cnt_r == TIMEOUT_LAST) begin
          state_nxt_s = PLL_RESET;
        end else begin
          state_nxt_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s) begin
          state_nxt_s = WAIT_LOCK;
        end else if (cnt_r == STABLE_LAST) begin
          state_nxt_s = RELEASE;
        end else begin
          state_nxt_s = STABLE;
        end
      end
      RELEASE: begin
        if (!lock_s) begin
          state_nxt_s = PLL_RESET;
        end else if (cnt_r == RELEASE_LAST) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt_s = PLL_RESET;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = PLL_RESET;
      end
    endcase
  end

  // Output logic: computes the next value of every registered output.
  always_comb begin
    pll_rst_nxt_s      = pll_rst_r;
    domain_rst_n_nxt_s = domain_rst_n_r;
    ready_nxt_s        = ready_r;
    retry_count_nxt_s  = retry_count_r;
    loss_count_nxt_s   = loss_count_r;
    case (state_r)
      PLL_RESET: begin
        if (state_nxt_s == WAIT_LOCK) begin
          pll_rst_nxt_s = 1'b0;
        end else begin
          pll_rst_nxt_s = 1'b1;
        end
      end
      WAIT_LOCK: begin
        if (state_nxt_s == PLL_RESET) begin
          pll_rst_nxt_s     = 1'b1;
          retry_count_nxt_s = sat_inc(retry_count_r);
        end else begin
          pll_rst_nxt_s     = 1'b0;
        end
      end
      STABLE: begin
        pll_rst_nxt_s = 1'b0;
      end
      RELEASE: begin
        if (!lock_s) begin
          pll_rst_nxt_s      = 1'b1;
          domain_rst_n_nxt_s = '0;
          ready_nxt_s        = 1'b0;
          loss_count_nxt_s   = sat_inc(loss_count_r);
        end else begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (cnt_r == 32'(i * STAGGER_CYCLES)) begin
              domain_rst_n_nxt_s[i] = 1'b1;
            end else begin
              domain_rst_n_nxt_s[i] = domain_rst_n_r[i];
            end
          end
          if (state_nxt_s == RUN) begin
            ready_nxt_s = 1'b1;
          end else begin
            ready_nxt_s = 1'b0;
          end
        end
      end
      RUN: begin
        if (!lock_s) begin
          pll_rst_nxt_s      = 1'b1;
          domain_rst_n_nxt_s = '0;
          ready_nxt_s        = 1'b0;
          loss_count_nxt_s   = sat_inc(loss_count_r);
        end else begin
          pll_rst_nxt_s      = 1'b0;
        end
      end
      default: begin
        pll_rst_nxt_s      = 1'b1;
        domain_rst_n_nxt_s = '0;
        ready_nxt_s        = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pll_rst_r      <= 1'b1;
      domain_rst_n_r <= '0;
      ready_r        <= 1'b0;
      retry_count_r  <= 8'd0;
      loss_count_r   <= 8'd0;
    end else begin
      pll_rst_r      <= pll_rst_nxt_s;
      domain_rst_n_r <= domain_rst_n_nxt_s;
      ready_r        <= ready_nxt_s;
      retry_count_r  <= retry_count_nxt_s;
      loss_count_r   <= loss_count_nxt_s;
    end
  end

  assign pll_rst      = pll_rst_r;
  assign domain_rst_n = domain_rst_n_r;
  assign ready        = ready_r;
  assign retry_count  = retry_count_r;
  assign loss_count   = loss_count_r;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed self-checking bench for pll_lock_supervisor with small timing
// parameters so every sequence can be counted edge by edge.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset_n;
  logic       locked_in;
  logic       pll_rst;
  logic [3:0] domain_rst_n;
  logic       ready;
  logic [7:0] retry_count;
  logic [7:0] loss_count;

  int checks;
  int errors;

  pll_lock_supervisor #(
    .SYNC_STAGES        (2),
    .RST_PULSE_CYCLES   (4),
    .LOCK_TIMEOUT_CYCLES(20),
    .LOCK_STABLE_CYCLES (4),
    .NUM_DOMAINS        (4),
    .STAGGER_CYCLES     (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .locked_in   (locked_in),
    .pll_rst     (pll_rst),
    .domain_rst_n(domain_rst_n),
    .ready       (ready),
    .retry_count (retry_count),
    .loss_count  (loss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in WAIT_LOCK with cnt 0; raises lock and checks each edge.
  task automatic bringup(input int drop_edge, input int last_edge);
    logic [3:0] exp_dom;
    locked_in = 1'b1;
    for (int e = 1; e <= last_edge; e++) begin
      tick();
      exp_dom = {(e >= 14), (e >= 12), (e >= 10), (e >= 8)};
      check_eq("bringup_dom", 32'(domain_rst_n), 32'(exp_dom));
      check_eq("bringup_ready", 32'(ready), 32'(e >= 14));
      check_eq("bringup_pll_rst", 32'(pll_rst), 32'd0);
      if (e == drop_edge) begin
        locked_in = 1'b0;
      end
    end
  endtask

  // Drops lock from RUN; resets assert on the third edge, then a 4-cycle pulse.
  task automatic lose_lock(input logic [7:0] exp_loss);
    locked_in = 1'b0;
    tick();
    tick();
    check_eq("loss_dom_held", 32'(domain_rst_n), 32'h0000000F);
    check_eq("loss_ready_held", 32'(ready), 32'd1);
    tick();
    check_eq("loss_dom", 32'(domain_rst_n), 32'd0);
    check_eq("loss_ready", 32'(ready), 32'd0);
    check_eq("loss_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("loss_count", 32'(loss_count), 32'(exp_loss));
    tick();
    tick();
    tick();
    check_eq("loss_pulse_high", 32'(pll_rst), 32'd1);
    tick();
    check_eq("loss_pulse_end", 32'(pll_rst), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    locked_in = 1'b1;

    repeat (3) tick();
    check_eq("rst_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("rst_dom", 32'(domain_rst_n), 32'd0);
    check_eq("rst_ready", 32'(ready), 32'd0);
    check_eq("rst_retry", 32'(retry_count), 32'd0);
    check_eq("rst_loss", 32'(loss_count), 32'd0);

    locked_in = 1'b0;
    reset_n   = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      check_eq("first_pulse_high", 32'(pll_rst), 32'd1);
    end
    tick();
    check_eq("first_pulse_end", 32'(pll_rst), 32'd0);

    bringup(0, 14);
    check_eq("bringup_retry", 32'(retry_count), 32'd0);

    lose_lock(8'd1);
    bringup(0, 14);

    lose_lock(8'd2);
    // Loss lands on the edge that would release domain 2.
    bringup(9, 11);
    tick();
    check_eq("midrel_dom", 32'(domain_rst_n), 32'd0);
    check_eq("midrel_ready", 32'(ready), 32'd0);
    check_eq("midrel_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("midrel_loss", 32'(loss_count), 32'd3);
    repeat (3) tick();
    check_eq("midrel_pulse_high", 32'(pll_rst), 32'd1);
    tick();
    check_eq("midrel_pulse_end", 32'(pll_rst), 32'd0);

    for (int k = 1; k <= 3; k++) begin
      repeat (19) tick();
      check_eq("to_before", 32'(pll_rst), 32'd0);
      tick();
      check_eq("to_pulse_start", 32'(pll_rst), 32'd1);
      check_eq("to_retry", 32'(retry_count), 32'(k));
      repeat (3) tick();
      check_eq("to_pulse_high", 32'(pll_rst), 32'd1);
      tick();
      check_eq("to_pulse_end", 32'(pll_rst), 32'd0);
    end
    repeat (297 * 24) tick();
    check_eq("to_retry_sat", 32'(retry_count), 32'd255);
    check_eq("to_sat_pll_rst", 32'(pll_rst), 32'd0);
    check_eq("to_sat_loss", 32'(loss_count), 32'd3);

    for (int g = 0; g < 10; g++) begin
      for (int p = 0; p < 4; p++) begin
        locked_in = (p < 3);
        tick();
        check_eq("unstable_ready", 32'(ready), 32'd0);
        check_eq("unstable_dom", 32'(domain_rst_n), 32'd0);
        check_eq("unstable_pll_rst", 32'(pll_rst), 32'd0);
      end
    end
    check_eq("unstable_loss", 32'(loss_count), 32'd3);
    locked_in = 1'b0;
    for (int e = 1; e <= 21; e++) begin
      tick();
      check_eq("unstable_low_wait", 32'(pll_rst), 32'd0);
    end
    tick();
    check_eq("unstable_timeout", 32'(pll_rst), 32'd1);
    check_eq("unstable_retry", 32'(retry_count), 32'd255);
    repeat (3) tick();
    tick();
    check_eq("unstable_pulse_end", 32'(pll_rst), 32'd0);

    bringup(0, 14);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_eq("async_pll_rst", 32'(pll_rst), 32'd1);
    check_eq("async_dom", 32'(domain_rst_n), 32'd0);
    check_eq("async_ready", 32'(ready), 32'd0);
    check_eq("async_retry", 32'(retry_count), 32'd0);
    check_eq("async_loss", 32'(loss_count), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the system PLL from its reference-clock domain. It drives the PLL reset, qualifies the asynchronous `locked` output through a synchronizer and a stability window, and then releases a set of per-domain resets in a staggered sequence. On lock loss it re-asserts all domain resets, pulses the PLL reset and counts the event. It sits between the PLL wrapper and the reset inputs of the fabric clock domains (video, D8M camera, motor control, HPS bridges).

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop stages on `locked_in`; legal range 2..4.
- `RST_PULSE_CYCLES`, 16: `pll_rst` high time, in clk cycles; must be ≥1.
- `LOCK_TIMEOUT_CYCLES`, 100000: cycles to wait for lock before retrying; must be ≥2.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-locked cycles required; must be ≥1.
- `NUM_DOMAINS`, 4: number of reset outputs; must be ≥1.
- `STAGGER_CYCLES`, 8: spacing between successive domain releases; must be ≥1.

Ports:
- `clk` in 1: free-running reference clock (the PLL `refclk`, 50 MHz).
- `reset_n` in 1: asynchronous, active-low reset; deassertion is synchronized to `clk` externally.
- `locked_in` in 1: PLL `locked`; asynchronous to `clk`.
- `pll_rst` out 1: active-high reset to the PLL `rst` input.
- `domain_rst_n` out NUM_DOMAINS: active-low resets, one per domain; bit 0 is released first.
- `ready` out 1: high while all domains are out of reset.
- `retry_count` out 8: number of lock timeouts; saturates at 255.
- `loss_count` out 8: number of lock losses after release began; saturates at 255.

## Operation
- Synchronizer: `lock_s` is `locked_in` delayed through `SYNC_STAGES` flip-flops. Synchronizer flops reset to 0. Only `lock_s` is used internally.
- All outputs are registered.
- One counter `cnt` is shared by all states and is cleared on every state transition.
- Reset state: state PLL_RESET, `cnt`=0, `pll_rst`=1, `domain_rst_n`=0, `ready`=0, both counters 0.

FSM states:
- **PLL_RESET**
  - `pll_rst`=1.
  - At the edge where `cnt`==RST_PULSE_CYCLES-1: go to WAIT_LOCK and drive `pll_rst` to 0.
- **WAIT_LOCK**
  - If `lock_s`=1: go to STABLE.
  - Else, at the edge where `cnt`==LOCK_TIMEOUT_CYCLES-1: go to PLL_RESET and increment `retry_count` (saturating).
- **STABLE**
  - If `lock_s`=0: go to WAIT_LOCK. This restarts the timeout window and does not change either counter.
  - At the edge where `lock_s`=1 and `cnt`==LOCK_STABLE_CYCLES-1: go to RELEASE.
- **RELEASE**
  - At the edge where `cnt`==i*STAGGER_CYCLES: set `domain_rst_n[i]` to 1.
  - At the edge where `cnt`==(NUM_DOMAINS-1)*STAGGER_CYCLES: also set `ready` to 1 and go to RUN.
- **RUN**
  - Hold all outputs.
- Lock loss in RELEASE or RUN (`lock_s`=0 at an edge):
  - That edge clears all `domain_rst_n` bits and `ready`, sets `pll_rst` to 1, increments `loss_count` (saturating) and goes to PLL_RESET.
  - Lock loss takes priority over any release scheduled on the same edge.
- Released domain bits stay 1 until lock loss or `reset_n`.
- Counters: an increment at 255 holds 255.
- `reset_n` asserted in any state immediately forces the reset state.

## Timing
- `locked_in` to `lock_s`: SYNC_STAGES edges.
- First edge at which WAIT_LOCK sees `lock_s`=1, to the first release (`domain_rst_n[0]`): LOCK_STABLE_CYCLES+1 edges. Domain i is released i*STAGGER_CYCLES edges after domain 0.
- `ready` rises on the same edge as `domain_rst_n[NUM_DOMAINS-1]`.
- Lock loss to all resets asserted: SYNC_STAGES+1 edges after the `locked_in` fall.
- `pll_rst` pulse width is exactly RST_PULSE_CYCLES cycles. From power-up, the first pulse begins at `reset_n` assertion and lasts RST_PULSE_CYCLES cycles after deassertion.
- A glitch on `locked_in` shorter than one cycle may be missed; this is acceptable.

## Test plan
Bench parameters unless stated: SYNC_STAGES=2, RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=4, NUM_DOMAINS=4, STAGGER_CYCLES=2.

- **Reset values:** hold `reset_n`=0 with `locked_in`=1 → `pll_rst`=1, `domain_rst_n`=4'b0000, `ready`=0, both counts 0. Release `reset_n` → `pll_rst` falls after exactly 4 edges.
- **Normal bring-up:** raise `locked_in` before edge 1 while in WAIT_LOCK →
  - `domain_rst_n[0]` rises at edge 8;
  - bits 1, 2, 3 rise at edges 10, 12, 14;
  - `ready`=1 at edge 14.
- **Timeout retry:** keep `locked_in`=0 → `pll_rst` re-pulses for 4 cycles every 24 cycles. `retry_count` reads 1, 2, 3; force 300 retries → `retry_count` reads 255.
- **Unstable lock:** `locked_in` high for 3 cycles, low for 1, repeated → `ready` never rises, `loss_count` stays 0, and the timeout fires only if `locked_in` stays low for 20 cycles.
- **Loss in RUN:** drop `locked_in` after `ready` → all `domain_rst_n`=0 and `ready`=0 exactly 3 edges after the fall, `loss_count`=1, then a 4-cycle `pll_rst` pulse. Relock → the normal bring-up sequence repeats.
- **Loss mid-release:** drop `locked_in` so the loss lands on the same edge as the `domain_rst_n[2]` release → bit 2 stays 0, bits 0 and 1 return to 0, `loss_count` increments, state goes to PLL_RESET.
- **Async reset mid-run:** assert `reset_n` mid-RUN → all outputs return to reset values within the same cycle.
